// File: rtl/bitlet_result_collector_if.sv
// -----------------------------------------------------------------------------
// bitlet_result_collector_if
//
// Bundles the result-input side and the packed-word output side of the
// Bitlet result collector.
//
// Handshake semantics (one rule for the whole interface):
//   * res_vld is a single-cycle strobe with no back-pressure. The producer
//     cannot be stalled, so every strobe is either captured or counted as lost
//     through the sticky overflow flag.
//   * out_vld/out_rdy is a strict valid/ready pair. A word transfers on a rising
//     edge where both are high. While out_vld && !out_rdy, out_data and out_mask
//     stay stable. out_vld never depends combinationally on out_rdy.
//
// Signals:
//   clr      producer -> collector  synchronous clear (highest priority)
//   flush    producer -> collector  emit partial word, zero padded
//   res_vld  producer -> collector  result strobe
//   res      producer -> collector  result value, WID bits
//   out_vld  collector -> consumer  packed word available
//   out_rdy  consumer -> collector  consumer accepts the word
//   out_data collector -> consumer  packed word, lane 0 = oldest result
//   out_mask collector -> consumer  valid-lane mask
//   level    collector -> consumer  FIFO occupancy
//   overflow collector -> consumer  sticky: a packed word was dropped
//
// Modports:
//   master : the environment (drives inputs, observes outputs)
//   slave  : the collector itself
// -----------------------------------------------------------------------------
interface bitlet_result_collector_if #(
    parameter int WID   = 32,
    parameter int PACK  = 2,
    parameter int DEPTH = 4
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic                 clr;
    logic                 flush;
    logic                 res_vld;
    logic [WID-1:0]       res;
    logic                 out_vld;
    logic                 out_rdy;
    logic [PACK*WID-1:0]  out_data;
    logic [PACK-1:0]      out_mask;
    logic [LVL_W-1:0]     level;
    logic                 overflow;

    modport master (
        output clr, flush, res_vld, res, out_rdy,
        input  out_vld, out_data, out_mask, level, overflow
    );

    modport slave (
        input  clr, flush, res_vld, res, out_rdy,
        output out_vld, out_data, out_mask, level, overflow
    );
endinterface

// File: rtl/bitlet_result_collector.sv
// -----------------------------------------------------------------------------
// bitlet_result_collector
//
// Downstream stage of the Bitlet post-processor. It captures single-cycle
// results, packs PACK consecutive results into one wide word, and buffers the
// packed words in a DEPTH-entry show-ahead FIFO. The FIFO drains over a
// valid/ready handshake. The producer cannot be stalled, so a word that finds
// the FIFO full is dropped and the sticky overflow flag is raised.
//
// Parameters:
//   WID    width of one result
//   PACK   results per packed word (>= 1)
//   DEPTH  FIFO depth in packed words (power of two, >= 2)
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    bitlet_result_collector_if.slave. It carries clr, flush, res_vld,
//          res and out_rdy in, and out_vld, out_data, out_mask, level and
//          overflow out.
// -----------------------------------------------------------------------------
module bitlet_result_collector #(
    parameter int WID   = 32,
    parameter int PACK  = 2,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    bitlet_result_collector_if.slave   bus
);
    localparam int CNT_W = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PACK - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    // ------------------------------------------------------------------
    // Packing register state
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]     cnt_q;
    logic [PACK*WID-1:0]  lane_q;

    // ------------------------------------------------------------------
    // FIFO state. The storage has no reset. Every output read of it is
    // gated by a non-zero level, so stale contents are never visible.
    // ------------------------------------------------------------------
    logic [PACK*WID-1:0]  mem_data [DEPTH];
    logic [PACK-1:0]      mem_mask [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [LVL_W-1:0]     level_q;
    logic                 ovf_q;

    // ------------------------------------------------------------------
    // Combinational next-state of the packing register
    // ------------------------------------------------------------------
    logic [PACK*WID-1:0]  lane_d;     // lanes including a same-cycle result
    logic [CNT_W-1:0]     cnt_after;  // lane count after a same-cycle result
    logic                 complete;   // this result fills the last lane
    logic                 push;       // a packed word leaves the packer
    logic [PACK*WID-1:0]  push_data;
    logic [PACK-1:0]      push_mask;
    logic                 pop;
    logic                 push_ok;
    logic                 drop;
    logic                 empty;

    always_comb begin
        lane_d    = lane_q;
        cnt_after = cnt_q;
        complete  = 1'b0;
        if (bus.res_vld) begin
            lane_d[int'(cnt_q)*WID +: WID] = bus.res;
            if (cnt_q == CNT_LAST) begin
                complete  = 1'b1;
                cnt_after = '0;
            end else begin
                cnt_after = cnt_q + CNT_W'(1);
            end
        end
    end

    // A completing result already pushes and leaves cnt_after at zero.
    // A coincident flush therefore adds no second word. A flush with no
    // pending lanes has no effect.
    assign push = complete || (bus.flush && (cnt_after != '0));

    // Lanes at or above the fill count still hold results from earlier
    // words. They are masked to zero here so partial words are zero-padded.
    always_comb begin
        push_mask = '0;
        push_data = '0;
        for (int i = 0; i < PACK; i++) begin
            push_mask[i] = complete || (i < int'(cnt_after));
            if (push_mask[i]) begin
                push_data[i*WID +: WID] = lane_d[i*WID +: WID];
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO control. A full FIFO still accepts a push when the head word
    // leaves on the same edge.
    // ------------------------------------------------------------------
    assign empty   = (level_q == '0);
    assign pop     = !empty && bus.out_rdy;
    assign push_ok = push && ((level_q != LVL_FULL) || pop);
    assign drop    = push && !push_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            lane_q  <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else if (bus.clr) begin
            // clr outranks everything in this cycle: results, flush and pops.
            cnt_q   <= '0;
            lane_q  <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            lane_q <= lane_d;
            // Any push resets the lane count, including a dropped one.
            cnt_q  <= push ? '0 : cnt_after;
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level_q <= level_q + LVL_W'(push_ok) - LVL_W'(pop);
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!bus.clr && push_ok) begin
            mem_data[wr_ptr] <= push_data;
            mem_mask[wr_ptr] <= push_mask;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. These are driven only from registers, so there is no
    // combinational path from out_rdy. The head entry is shown ahead, and
    // the outputs read zero while empty, including during reset.
    // ------------------------------------------------------------------
    assign bus.out_vld  = !empty;
    assign bus.out_data = empty ? '0 : mem_data[rd_ptr];
    assign bus.out_mask = empty ? '0 : mem_mask[rd_ptr];
    assign bus.level    = level_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_bitlet_result_collector.sv
module tb_bitlet_result_collector;
    localparam int WID   = 32;
    localparam int PACK  = 2;
    localparam int DEPTH = 4;
    localparam int DW    = PACK * WID;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    bitlet_result_collector_if #(.WID(WID), .PACK(PACK), .DEPTH(DEPTH)) bus ();

    bitlet_result_collector #(.WID(WID), .PACK(PACK), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // ---------------- reference model ----------------
    // Pending results waiting to form a word, the queue of words in the
    // FIFO, and the sticky loss flag.
    logic [WID-1:0]  pend_q[$];
    logic [DW-1:0]   exp_q[$];
    logic [PACK-1:0] expm_q[$];
    bit              exp_ovf;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic model_reset();
        pend_q.delete();
        exp_q.delete();
        expm_q.delete();
        exp_ovf = 1'b0;
    endtask

    task automatic model_edge(input bit v, input logic [WID-1:0] r,
                              input bit f, input bit c, input bit rdy);
        logic [DW-1:0]   w;
        logic [PACK-1:0] m;
        if (c) begin
            model_reset();
            return;
        end
        if (exp_q.size() != 0 && rdy) begin
            void'(exp_q.pop_front());
            void'(expm_q.pop_front());
        end
        if (v) pend_q.push_back(r);
        if (pend_q.size() == PACK || (f && pend_q.size() != 0)) begin
            w = '0;
            m = '0;
            foreach (pend_q[i]) begin
                w[i*WID +: WID] = pend_q[i];
                m[i]            = 1'b1;
            end
            if (exp_q.size() < DEPTH) begin
                exp_q.push_back(w);
                expm_q.push_back(m);
            end else begin
                exp_ovf = 1'b1;
            end
            pend_q.delete();
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [DW-1:0] obs,
                         input logic [DW-1:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        logic [DW-1:0]   ed;
        logic [PACK-1:0] em;
        ed = (exp_q.size() != 0) ? exp_q[0]  : '0;
        em = (exp_q.size() != 0) ? expm_q[0] : '0;
        check({tag, "_vld"},   DW'(bus.out_vld),  DW'(exp_q.size() != 0));
        check({tag, "_data"},  bus.out_data,      ed);
        check({tag, "_mask"},  DW'(bus.out_mask), DW'(em));
        check({tag, "_level"}, DW'(bus.level),    DW'(exp_q.size()));
        check({tag, "_ovf"},   DW'(bus.overflow), DW'(exp_ovf));
    endtask

    // ---------------- driver ----------------
    // Inputs are applied just after an edge. The next rising edge samples
    // them, the model advances, and outputs are checked 1 time unit later.
    task automatic step(input string tag, input bit v, input logic [WID-1:0] r,
                        input bit f, input bit c, input bit rdy);
        bus.res_vld = v;
        bus.res     = r;
        bus.flush   = f;
        bus.clr     = c;
        bus.out_rdy = rdy;
        @(posedge clk);
        model_edge(v, r, f, c, rdy);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input bit rdy);
        step(tag, 1'b0, '0, 1'b0, 1'b0, rdy);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.res_vld = 1'b0;
        bus.res     = '0;
        bus.flush   = 1'b0;
        bus.clr     = 1'b0;
        bus.out_rdy = 1'b0;
        model_reset();

        #2 rst_n = 1'b0;
        #1 check_all("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Basic pack
        step("bp1", 1'b1, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
        step("bp2", 1'b1, 32'h2222_2222, 1'b0, 1'b0, 1'b0);
        check("bp_data_const",  bus.out_data,      64'h2222_2222_1111_1111);
        check("bp_mask_const",  DW'(bus.out_mask), DW'(2'b11));
        check("bp_level_const", DW'(bus.level),    DW'(1));
        idle("bp_pop", 1'b1);
        check("bp_level0_const", DW'(bus.level), DW'(0));

        // Flush partial
        step("fp1", 1'b1, 32'hAAAA_5555, 1'b0, 1'b0, 1'b0);
        idle("fp_gap", 1'b0);
        step("fp_flush", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("fp_data_const", bus.out_data,      64'h0000_0000_AAAA_5555);
        check("fp_mask_const", DW'(bus.out_mask), DW'(2'b01));
        step("fp_flush2", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("fp_level_const", DW'(bus.level), DW'(1));
        idle("fp_drain", 1'b1);

        // Flush coincident with the completing result
        step("fc1", 1'b1, 32'hA0A0_0001, 1'b0, 1'b0, 1'b0);
        step("fc2", 1'b1, 32'hB0B0_0002, 1'b1, 1'b0, 1'b0);
        check("fc_data_const",  bus.out_data,      64'hB0B0_0002_A0A0_0001);
        check("fc_mask_const",  DW'(bus.out_mask), DW'(2'b11));
        check("fc_level_const", DW'(bus.level),    DW'(1));
        idle("fc_drain", 1'b1);

        // Full and overflow
        for (int i = 0; i < 10; i++) begin
            step("full_in", 1'b1, $urandom, 1'b0, 1'b0, 1'b0);
            if (i == 7) check("full_level_const", DW'(bus.level), DW'(4));
        end
        check("ovf_const", DW'(bus.overflow), DW'(1));
        for (int i = 0; i < 4; i++) idle("drain", 1'b1);
        check("drain_level_const", DW'(bus.level),    DW'(0));
        check("drain_ovf_const",   DW'(bus.overflow), DW'(1));
        step("clr_ovf", 1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Full with simultaneous pop
        for (int i = 0; i < 8; i++) step("fsp_fill", 1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        step("fsp_half", 1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        step("fsp_push", 1'b1, $urandom, 1'b0, 1'b0, 1'b1);
        check("fsp_level_const", DW'(bus.level),    DW'(4));
        check("fsp_ovf_const",   DW'(bus.overflow), DW'(0));
        step("fsp_clr", 1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-operation (level 3, one pending lane)
        for (int i = 0; i < 7; i++) step("rst_fill", 1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        check("rst_pre_level_const", DW'(bus.level), DW'(3));
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all("rst_async");
        @(negedge clk) rst_n = 1'b1;
        step("rst_r1", 1'b1, 32'hC0DE_0001, 1'b0, 1'b0, 1'b0);
        step("rst_r2", 1'b1, 32'hC0DE_0002, 1'b0, 1'b0, 1'b0);
        check("rst_word_const", bus.out_data, 64'hC0DE_0002_C0DE_0001);
        step("rst_clr", 1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Synchronous clear mid-operation
        for (int i = 0; i < 7; i++) step("clr_fill", 1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        step("clr_mid", 1'b1, $urandom, 1'b1, 1'b1, 1'b1);
        step("clr_r1", 1'b1, 32'hD00D_0001, 1'b0, 1'b0, 1'b0);
        step("clr_r2", 1'b1, 32'hD00D_0002, 1'b0, 1'b0, 1'b0);
        check("clr_word_const", bus.out_data, 64'hD00D_0002_D00D_0001);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 1'($urandom_range(0, 1)),
                 $urandom,
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 3) != 0));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
